conv_1x1_layer_sched: RTL and testbench

//  Sequences one 1x1 conv layer (e.g. 304->256) on the shared conv_1x1 engine, one output channel per pass.

---
 rtl/conv_1x1_layer_sched.sv | 215 +++++++++++++++++++++
 tb/tb_conv_1x1_layer_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_layer_sched.sv
// Layer sequencer for the shared 1x1 conv engine: per output channel it loads the
// weights, streams one input frame into the engine, then waits for that pass's results.
module conv_1x1_layer_sched #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 304,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int PIXELS_PER_PASS = 4096,
  parameter int OUT_PER_PASS    = 1024,
  parameter int OUT_PER_PASS_S2 = 256,
  parameter int ADDR_WIDTH      = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stride2_cfg,
  output logic                  w_rd_req,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  input  logic                  w_rd_valid,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  input  logic                  pxl_valid_in,
  output logic                  pxl_ready,
  input  logic [DATA_WIDTH-1:0] pxl_data_in,
  output logic                  eng_valid_in,
  output logic [DATA_WIDTH-1:0] eng_pxl_in,
  output logic                  eng_stride2,
  input  logic                  eng_valid_out,
  output logic [8:0]            oc_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int IC_W = $clog2(CHANNEL_NUM_IN + 1);
  localparam int PX_W = $clog2(PIXELS_PER_PASS + 1);
  localparam int RS_W = $clog2(OUT_PER_PASS + 1);

  localparam logic [IC_W-1:0]       IC_LAST = IC_W'(CHANNEL_NUM_IN - 1);
  localparam logic [PX_W-1:0]       PX_LAST = PX_W'(PIXELS_PER_PASS - 1);
  localparam logic [RS_W-1:0]       RS_FULL = RS_W'(OUT_PER_PASS);
  localparam logic [RS_W-1:0]       RS_S2   = RS_W'(OUT_PER_PASS_S2);
  localparam logic [8:0]            OC_LAST = 9'(CHANNEL_NUM_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] W_STEP  = ADDR_WIDTH'(CHANNEL_NUM_IN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [8:0]            oc_q, oc_d;
  logic [IC_W-1:0]       req_cnt_q, req_cnt_d;
  logic [IC_W-1:0]       rcv_cnt_q, rcv_cnt_d;
  logic [PX_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [RS_W-1:0]       res_cnt_q, res_cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  w_rd_req_q, w_rd_req_d;
  logic [ADDR_WIDTH-1:0] w_rd_addr_q, w_rd_addr_d;
  logic                  valid_weight_out_q, valid_weight_out_d;
  logic [DATA_WIDTH-1:0] weight_out_q, weight_out_d;
  logic                  eng_valid_in_q, eng_valid_in_d;
  logic [DATA_WIDTH-1:0] eng_pxl_in_q, eng_pxl_in_d;
  logic                  eng_stride2_q, eng_stride2_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [RS_W-1:0]       res_target;

  assign w_rd_req         = w_rd_req_q;
  assign w_rd_addr        = w_rd_addr_q;
  assign valid_weight_out = valid_weight_out_q;
  assign weight_out       = weight_out_q;
  assign pxl_ready        = (state_q == S_STREAM);
  assign eng_valid_in     = eng_valid_in_q;
  assign eng_pxl_in       = eng_pxl_in_q;
  assign eng_stride2      = eng_stride2_q;
  assign oc_idx           = oc_q;
  assign busy             = busy_q;
  assign done             = done_q;

  always_comb begin
    state_d            = state_q;
    oc_d               = oc_q;
    req_cnt_d          = req_cnt_q;
    rcv_cnt_d          = rcv_cnt_q;
    pix_cnt_d          = pix_cnt_q;
    res_cnt_d          = res_cnt_q;
    base_d             = base_q;
    w_rd_req_d         = w_rd_req_q;
    w_rd_addr_d        = w_rd_addr_q;
    valid_weight_out_d = 1'b0;
    weight_out_d       = weight_out_q;
    eng_valid_in_d     = 1'b0;
    eng_pxl_in_d       = eng_pxl_in_q;
    eng_stride2_d      = eng_stride2_q;
    busy_d             = busy_q;
    done_d             = 1'b0;
    res_target         = eng_stride2_q ? RS_S2 : RS_FULL;

    // Engine results may overlap weight load and streaming; saturate so a pass never wraps.
    if ((state_q == S_LOAD_W || state_q == S_STREAM || state_q == S_DRAIN) &&
        eng_valid_out && (res_cnt_q != res_target)) begin
      res_cnt_d = res_cnt_q + RS_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD_W;
          busy_d        = 1'b1;
          eng_stride2_d = stride2_cfg;
          oc_d          = '0;
          base_d        = '0;
          w_rd_req_d    = 1'b1;
          w_rd_addr_d   = '0;
          req_cnt_d     = '0;
          rcv_cnt_d     = '0;
          pix_cnt_d     = '0;
          res_cnt_d     = '0;
        end
      end
      S_LOAD_W: begin
        if (w_rd_req_q) begin
          req_cnt_d   = req_cnt_q + IC_W'(1);
          w_rd_addr_d = w_rd_addr_q + ADDR_WIDTH'(1);
          if (req_cnt_q == IC_LAST) w_rd_req_d = 1'b0;
        end
        if (w_rd_valid) begin
          valid_weight_out_d = 1'b1;
          weight_out_d       = w_rd_data;
          rcv_cnt_d          = rcv_cnt_q + IC_W'(1);
          if (rcv_cnt_q == IC_LAST) begin
            state_d   = S_STREAM;
            pix_cnt_d = '0;
          end
        end
      end
      S_STREAM: begin
        if (pxl_valid_in) begin
          eng_valid_in_d = 1'b1;
          eng_pxl_in_d   = pxl_data_in;
          pix_cnt_d      = pix_cnt_q + PX_W'(1);
          if (pix_cnt_q == PX_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_cnt_q == res_target) begin
          res_cnt_d = '0;
          if (oc_q == OC_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_LOAD_W;
            oc_d        = oc_q + 9'd1;
            base_d      = base_q + W_STEP;
            w_rd_addr_d = base_q + W_STEP;
            w_rd_req_d  = 1'b1;
            req_cnt_d   = '0;
            rcv_cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d       = S_IDLE;
        busy_d        = 1'b0;
        oc_d          = '0;
        eng_stride2_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      oc_q               <= '0;
      req_cnt_q          <= '0;
      rcv_cnt_q          <= '0;
      pix_cnt_q          <= '0;
      res_cnt_q          <= '0;
      base_q             <= '0;
      w_rd_req_q         <= 1'b0;
      w_rd_addr_q        <= '0;
      valid_weight_out_q <= 1'b0;
      weight_out_q       <= '0;
      eng_valid_in_q     <= 1'b0;
      eng_pxl_in_q       <= '0;
      eng_stride2_q      <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      oc_q               <= oc_d;
      req_cnt_q          <= req_cnt_d;
      rcv_cnt_q          <= rcv_cnt_d;
      pix_cnt_q          <= pix_cnt_d;
      res_cnt_q          <= res_cnt_d;
      base_q             <= base_d;
      w_rd_req_q         <= w_rd_req_d;
      w_rd_addr_q        <= w_rd_addr_d;
      valid_weight_out_q <= valid_weight_out_d;
      weight_out_q       <= weight_out_d;
      eng_valid_in_q     <= eng_valid_in_d;
      eng_pxl_in_q       <= eng_pxl_in_d;
      eng_stride2_q      <= eng_stride2_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_1x1_layer_sched.sv
// Bench for conv_1x1_layer_sched: memory, pixel-source and engine models plus
// scoreboards for weight/pixel order, driven by a table of layer scenarios.
module tb_conv_1x1_layer_sched;

  localparam int DW = 32;
  localparam int AW = 17;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stride2_cfg;
  logic          w_rd_req;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_valid;
  logic [DW-1:0] w_rd_data;
  logic          valid_weight_out;
  logic [DW-1:0] weight_out;
  logic          pxl_valid_in;
  logic          pxl_ready;
  logic [DW-1:0] pxl_data_in;
  logic          eng_valid_in;
  logic [DW-1:0] eng_pxl_in;
  logic          eng_stride2;
  logic          eng_valid_out;
  logic [8:0]    oc_idx;
  logic          busy;
  logic          done;

  conv_1x1_layer_sched #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2), .PIXELS_PER_PASS(16),
    .OUT_PER_PASS(4), .OUT_PER_PASS_S2(1), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .stride2_cfg(stride2_cfg),
    .w_rd_req(w_rd_req), .w_rd_addr(w_rd_addr), .w_rd_valid(w_rd_valid), .w_rd_data(w_rd_data),
    .valid_weight_out(valid_weight_out), .weight_out(weight_out),
    .pxl_valid_in(pxl_valid_in), .pxl_ready(pxl_ready), .pxl_data_in(pxl_data_in),
    .eng_valid_in(eng_valid_in), .eng_pxl_in(eng_pxl_in), .eng_stride2(eng_stride2),
    .eng_valid_out(eng_valid_out), .oc_idx(oc_idx), .busy(busy), .done(done)
  );

  typedef struct {
    logic stride;
    logic rnd;
    logic stray;
    logic start_busy;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  logic          stride_mode = 1'b0;
  logic          rand_valid  = 1'b0;
  logic          stray_req   = 1'b0;
  logic          stray_done  = 1'b0;
  logic [DW-1:0] exp_w[$];
  logic [DW-1:0] exp_p[$];
  int            exp_addr;
  int            pix_sent = 0;
  int            in_per_oc[2];
  int            wv_count, done_count, ready_viol, stride_viol, busy_viol;
  int            oc_steps, oc_bad, eng_in_cnt;
  logic          prev_done = 1'b0;
  logic [8:0]    last_oc = '0;
  logic [1:0]    pipe_v = '0;
  logic [AW-1:0] pipe_a[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic clearLayerStats();
    exp_addr = 0;
    in_per_oc[0] = 0;
    in_per_oc[1] = 0;
    wv_count = 0; done_count = 0; ready_viol = 0; stride_viol = 0; busy_viol = 0;
    oc_steps = 0; oc_bad = 0; stray_done = 1'b0;
    exp_w.delete();
    exp_p.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_w_rd_req"}, w_rd_req, 0);
    checkOutput({tag, "_w_rd_addr"}, w_rd_addr, 0);
    checkOutput({tag, "_valid_weight_out"}, valid_weight_out, 0);
    checkOutput({tag, "_weight_out"}, weight_out, 0);
    checkOutput({tag, "_pxl_ready"}, pxl_ready, 0);
    checkOutput({tag, "_eng_valid_in"}, eng_valid_in, 0);
    checkOutput({tag, "_eng_pxl_in"}, eng_pxl_in, 0);
    checkOutput({tag, "_eng_stride2"}, eng_stride2, 0);
    checkOutput({tag, "_oc_idx"}, oc_idx, 0);
  endtask

  // Pixel scoreboard push: every beat the DUT accepts must reappear on eng_pxl_in in order.
  always @(posedge clk) begin
    if (rst_n && pxl_valid_in && pxl_ready) begin
      exp_p.push_back(pxl_data_in);
      pix_sent++;
    end
  end

  // Output checks first, then the memory, engine and pixel-source models drive new inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      pipe_v        = '0;
      w_rd_valid    = 1'b0;
      eng_valid_out = 1'b0;
      eng_in_cnt    = 0;
      pxl_valid_in  = 1'b0;
      prev_done     = 1'b0;
    end else begin
      if (valid_weight_out) begin
        wv_count++;
        if (exp_w.size() == 0) checkOutput("weight_unexpected", 1, 0);
        else checkOutput("weight_out", weight_out, exp_w.pop_front());
      end
      if (w_rd_req) begin
        checkOutput("w_rd_addr", w_rd_addr, exp_addr);
        exp_addr++;
        if (pxl_ready) ready_viol++;
      end
      if (!busy && pxl_ready) ready_viol++;
      if (busy && eng_stride2 !== stride_mode) stride_viol++;
      if (done) begin
        done_count++;
        if (!busy) busy_viol++;
      end
      if (prev_done && busy) busy_viol++;
      prev_done = done;
      if (busy && oc_idx != last_oc) begin
        if (oc_idx == last_oc + 9'd1) oc_steps++;
        else oc_bad++;
      end
      last_oc = oc_idx;

      eng_valid_out = 1'b0;
      if (eng_valid_in) begin
        if (oc_idx < 9'd2) in_per_oc[oc_idx]++;
        else oc_bad++;
        if (exp_p.size() == 0) checkOutput("pxl_unexpected", 1, 0);
        else checkOutput("eng_pxl_in", eng_pxl_in, exp_p.pop_front());
        eng_in_cnt++;
        if (eng_in_cnt % (stride_mode ? 16 : 4) == 0) eng_valid_out = 1'b1;
      end

      w_rd_valid = pipe_v[1];
      w_rd_data  = 32'hA000_0000 | {15'd0, pipe_a[1]};
      if (pipe_v[1]) exp_w.push_back(w_rd_data);
      if (stray_req && !stray_done && pxl_ready && !pipe_v[1]) begin
        w_rd_valid = 1'b1;
        w_rd_data  = 32'hDEAD_BEEF;
        stray_done = 1'b1;
      end
      pipe_v[1] = pipe_v[0];
      pipe_a[1] = pipe_a[0];
      pipe_v[0] = w_rd_req;
      pipe_a[0] = w_rd_addr;

      pxl_valid_in = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      pxl_data_in  = 32'h5000_0000 + pix_sent;
    end
  end

  task automatic applyStimulus(input vec_t v);
    logic sb_done;
    bit   finished;
    sb_done  = 1'b0;
    finished = 1'b0;
    clearLayerStats();
    stride_mode = v.stride;
    rand_valid  = v.rnd;
    stray_req   = v.stray;
    @(negedge clk); #1;
    start       = 1'b1;
    stride2_cfg = v.stride;
    @(negedge clk); #1;
    start       = 1'b0;
    stride2_cfg = ~v.stride;
    checkOutput("busy_after_start", busy, 1);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (v.start_busy && !sb_done && in_per_oc[0] >= 5) begin
        start   = 1'b1;
        sb_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_count > 0) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checkOutput("done_seen_in_budget", finished, 1);
  endtask

  task automatic checkLayer(input vec_t v);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("done_count", done_count, 1);
    checkOutput("pixels_oc0", in_per_oc[0], 16);
    checkOutput("pixels_oc1", in_per_oc[1], 16);
    checkOutput("weights_fwd", wv_count, 8);
    checkOutput("addrs_issued", exp_addr, 8);
    checkOutput("pxl_left", exp_p.size(), 0);
    checkOutput("w_left", exp_w.size(), 0);
    checkOutput("ready_viol", ready_viol, 0);
    checkOutput("stride_viol", stride_viol, 0);
    checkOutput("busy_done_viol", busy_viol, 0);
    checkOutput("oc_steps", oc_steps, 1);
    checkOutput("oc_bad", oc_bad, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_oc_idx", oc_idx, 0);
    checkOutput("idle_pxl_ready", pxl_ready, 0);
    if (v.stray) checkOutput("stray_injected", stray_done, 1);
  endtask

  initial begin
    vecs[0] = '{stride: 1'b0, rnd: 1'b0, stray: 1'b0, start_busy: 1'b0};
    vecs[1] = '{stride: 1'b0, rnd: 1'b1, stray: 1'b0, start_busy: 1'b0};
    vecs[2] = '{stride: 1'b1, rnd: 1'b0, stray: 1'b0, start_busy: 1'b0};
    vecs[3] = '{stride: 1'b0, rnd: 1'b0, stray: 1'b1, start_busy: 1'b1};
    vecs[4] = '{stride: 1'b1, rnd: 1'b1, stray: 1'b1, start_busy: 1'b1};

    rst_n       = 1'b0;
    start       = 1'b0;
    stride2_cfg = 1'b0;
    pxl_data_in = '0;
    w_rd_data   = '0;
    clearLayerStats();
    repeat (3) @(negedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] layer scenario %0d", i);
      applyStimulus(vecs[i]);
      checkLayer(vecs[i]);
    end

    // Abort in the middle of the second pass, then a fresh layer must start from address 0.
    $display("[TB] reset during STREAM of oc 1");
    begin
      bit reached;
      reached = 1'b0;
      clearLayerStats();
      stride_mode = 1'b0;
      rand_valid  = 1'b0;
      stray_req   = 1'b0;
      @(negedge clk); #1;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk); #1;
        if (oc_idx == 9'd1 && pxl_ready && in_per_oc[1] >= 3) begin
          reached = 1'b1;
          break;
        end
      end
      checkOutput("reached_oc1_stream", reached, 1);
      rst_n = 1'b0;
      #1;
      checkAllZero("abort");
      repeat (3) @(negedge clk);
      #1;
      checkOutput("abort_no_done", done_count, 0);
      checkOutput("abort_still_idle", busy, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(vecs[0]);
      checkLayer(vecs[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
